// File: rtl/vive_pkg.sv
// Shared widths, polynomial constants and scheduler state encoding for the tracker datapath.
package vive_pkg;

    localparam int unsigned TS_W   = 24;
    localparam int unsigned LFSR_W = 17;
    localparam int unsigned TMO_W  = 22;

    localparam logic [LFSR_W-1:0] POLY_1D258 = 17'h1d258;
    localparam logic [LFSR_W-1:0] POLY_17E04 = 17'h17e04;

    typedef enum logic [2:0] {
        FLUSH   = 3'd0,
        IDLE    = 3'd1,
        START   = 3'd2,
        BUSY    = 3'd3,
        RELEASE = 3'd4
    } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: lowest-index requester at or after last_grant+1, wrapping.
module rr_arbiter #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last_grant,
    input  logic             advance,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx
);

    logic              found;
    int unsigned       cand;
    logic [IDX_W-1:0]  cand_idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        for (int unsigned i = 1; i <= N; i++) begin
            cand     = (32'(last_grant) + i) % N;
            cand_idx = IDX_W'(cand);
            if (!found && req[cand_idx]) begin
                found     = 1'b1;
                grant_idx = cand_idx;
            end
        end
        if (advance && found) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/polynomial_finder_scheduler.sv
// Time-shares one polynomial_finder between N_CHANNELS decode channels with
// round-robin grants, an enable/ready handshake and a saturating job timeout.
module polynomial_finder_scheduler
    import vive_pkg::*;
#(
    parameter int unsigned N_CHANNELS     = 4,
    parameter int unsigned CH_W           = 2,
    parameter int unsigned TIMEOUT_CYCLES = 2097152,
    parameter int unsigned RELEASE_CYCLES = 2
) (
    input  logic                         clk_72MHz,
    input  logic                         rst_n,
    input  logic [N_CHANNELS-1:0]        req,
    input  logic [TS_W*N_CHANNELS-1:0]   ts0,
    input  logic [TS_W*N_CHANNELS-1:0]   ts1,
    input  logic [LFSR_W*N_CHANNELS-1:0] data0,
    input  logic [LFSR_W*N_CHANNELS-1:0] data1,
    output logic [N_CHANNELS-1:0]        ack,
    output logic [TS_W-1:0]              fnd_ts_last_data,
    output logic [TS_W-1:0]              fnd_ts_last_data1,
    output logic [LFSR_W-1:0]            fnd_decoded_data,
    output logic [LFSR_W-1:0]            fnd_decoded_data1,
    output logic                         fnd_enable,
    input  logic                         fnd_ready,
    input  logic [LFSR_W-1:0]            fnd_polynomial,
    input  logic [LFSR_W-1:0]            fnd_iteration,
    output logic                         res_valid,
    output logic [CH_W-1:0]              res_channel,
    output logic [LFSR_W-1:0]            res_polynomial,
    output logic [LFSR_W-1:0]            res_iteration,
    output logic                         res_timeout
);

    localparam int unsigned        REL_W    = $clog2(RELEASE_CYCLES + 1);
    localparam logic [REL_W-1:0]   REL_LAST = REL_W'(RELEASE_CYCLES - 1);
    localparam logic [TMO_W-1:0]   TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    sched_state_t        state_q, state_d;
    logic [CH_W-1:0]     last_grant_q, last_grant_d;
    logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic [REL_W-1:0]    rel_cnt_q, rel_cnt_d;

    logic [N_CHANNELS-1:0] ack_d;
    logic [TS_W-1:0]       fnd_ts_last_data_d, fnd_ts_last_data1_d;
    logic [LFSR_W-1:0]     fnd_decoded_data_d, fnd_decoded_data1_d;
    logic                  fnd_enable_d;
    logic                  res_valid_d;
    logic [CH_W-1:0]       res_channel_d;
    logic [LFSR_W-1:0]     res_polynomial_d, res_iteration_d;
    logic                  res_timeout_d;

    logic [N_CHANNELS-1:0] grant_c;
    logic [CH_W-1:0]       grant_idx_c;
    logic                  tmo_hit_c;

    logic [TS_W-1:0]   ts0_ch   [N_CHANNELS];
    logic [TS_W-1:0]   ts1_ch   [N_CHANNELS];
    logic [LFSR_W-1:0] data0_ch [N_CHANNELS];
    logic [LFSR_W-1:0] data1_ch [N_CHANNELS];

    // Unflatten per-channel fields so the winner can be selected by index.
    for (genvar k = 0; k < N_CHANNELS; k++) begin : g_ch
        assign ts0_ch[k]   = ts0[k*TS_W +: TS_W];
        assign ts1_ch[k]   = ts1[k*TS_W +: TS_W];
        assign data0_ch[k] = data0[k*LFSR_W +: LFSR_W];
        assign data1_ch[k] = data1[k*LFSR_W +: LFSR_W];
    end

    rr_arbiter #(
        .N     (N_CHANNELS),
        .IDX_W (CH_W)
    ) u_rr_arbiter (
        .req        (req),
        .last_grant (last_grant_q),
        .advance    (state_q == IDLE),
        .grant      (grant_c),
        .grant_idx  (grant_idx_c)
    );

    assign tmo_hit_c = (tmo_cnt_q == TMO_LAST);

    // Next-state and next-output logic; every registered output holds by default.
    always_comb begin
        state_d             = state_q;
        last_grant_d        = last_grant_q;
        tmo_cnt_d           = tmo_cnt_q;
        rel_cnt_d           = rel_cnt_q;
        ack_d               = '0;
        fnd_ts_last_data_d  = fnd_ts_last_data;
        fnd_ts_last_data1_d = fnd_ts_last_data1;
        fnd_decoded_data_d  = fnd_decoded_data;
        fnd_decoded_data1_d = fnd_decoded_data1;
        fnd_enable_d        = fnd_enable;
        res_valid_d         = 1'b0;
        res_channel_d       = res_channel;
        res_polynomial_d    = res_polynomial;
        res_iteration_d     = res_iteration;
        res_timeout_d       = res_timeout;

        case (state_q)
            // The finder has no reset, so both paths hold enable low long enough for it to idle.
            FLUSH, RELEASE: begin
                fnd_enable_d = 1'b0;
                if (rel_cnt_q == REL_LAST) begin
                    rel_cnt_d = '0;
                    state_d   = IDLE;
                end else begin
                    rel_cnt_d = rel_cnt_q + 1'b1;
                end
            end

            IDLE: begin
                if (|req) begin
                    fnd_ts_last_data_d  = ts0_ch[grant_idx_c];
                    fnd_ts_last_data1_d = ts1_ch[grant_idx_c];
                    fnd_decoded_data_d  = data0_ch[grant_idx_c];
                    fnd_decoded_data1_d = data1_ch[grant_idx_c];
                    ack_d               = grant_c;
                    fnd_enable_d        = 1'b1;
                    last_grant_d        = grant_idx_c;
                    tmo_cnt_d           = '0;
                    state_d             = START;
                end
            end

            // Ready low proves the finder has left its idle state and accepted the job.
            START: begin
                if (tmo_hit_c) begin
                    fnd_enable_d     = 1'b0;
                    res_valid_d      = 1'b1;
                    res_channel_d    = last_grant_q;
                    res_polynomial_d = '0;
                    res_iteration_d  = '0;
                    res_timeout_d    = 1'b1;
                    rel_cnt_d        = '0;
                    state_d          = RELEASE;
                end else begin
                    if (tmo_cnt_q != '1) begin
                        tmo_cnt_d = tmo_cnt_q + 1'b1;
                    end
                    if (!fnd_ready) begin
                        state_d = BUSY;
                    end
                end
            end

            // A ready seen in the same cycle as the timeout still delivers the real result.
            BUSY: begin
                if (fnd_ready) begin
                    fnd_enable_d     = 1'b0;
                    res_valid_d      = 1'b1;
                    res_channel_d    = last_grant_q;
                    res_polynomial_d = fnd_polynomial;
                    res_iteration_d  = fnd_iteration;
                    res_timeout_d    = 1'b0;
                    rel_cnt_d        = '0;
                    state_d          = RELEASE;
                end else if (tmo_hit_c) begin
                    fnd_enable_d     = 1'b0;
                    res_valid_d      = 1'b1;
                    res_channel_d    = last_grant_q;
                    res_polynomial_d = '0;
                    res_iteration_d  = '0;
                    res_timeout_d    = 1'b1;
                    rel_cnt_d        = '0;
                    state_d          = RELEASE;
                end else if (tmo_cnt_q != '1) begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end

            default: begin
                fnd_enable_d = 1'b0;
                rel_cnt_d    = '0;
                state_d      = FLUSH;
            end
        endcase
    end

    always_ff @(posedge clk_72MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= FLUSH;
            last_grant_q      <= CH_W'(N_CHANNELS - 1);
            tmo_cnt_q         <= '0;
            rel_cnt_q         <= '0;
            ack               <= '0;
            fnd_ts_last_data  <= '0;
            fnd_ts_last_data1 <= '0;
            fnd_decoded_data  <= '0;
            fnd_decoded_data1 <= '0;
            fnd_enable        <= 1'b0;
            res_valid         <= 1'b0;
            res_channel       <= '0;
            res_polynomial    <= '0;
            res_iteration     <= '0;
            res_timeout       <= 1'b0;
        end else begin
            state_q           <= state_d;
            last_grant_q      <= last_grant_d;
            tmo_cnt_q         <= tmo_cnt_d;
            rel_cnt_q         <= rel_cnt_d;
            ack               <= ack_d;
            fnd_ts_last_data  <= fnd_ts_last_data_d;
            fnd_ts_last_data1 <= fnd_ts_last_data1_d;
            fnd_decoded_data  <= fnd_decoded_data_d;
            fnd_decoded_data1 <= fnd_decoded_data1_d;
            fnd_enable        <= fnd_enable_d;
            res_valid         <= res_valid_d;
            res_channel       <= res_channel_d;
            res_polynomial    <= res_polynomial_d;
            res_iteration     <= res_iteration_d;
            res_timeout       <= res_timeout_d;
        end
    end

endmodule

// File: tb/tb_polynomial_finder_scheduler.sv
// Bench for polynomial_finder_scheduler: behavioural finder, round-robin reference and job scoreboard.
module tb_polynomial_finder_scheduler;
    import vive_pkg::*;

    localparam int unsigned N       = 4;
    localparam int unsigned CW      = 2;
    localparam int unsigned TMO     = 64;
    localparam int unsigned REL     = 2;

    logic                 clk_72MHz = 1'b0;
    logic                 rst_n;
    logic [N-1:0]         req;
    logic [TS_W*N-1:0]    ts0, ts1;
    logic [LFSR_W*N-1:0]  data0, data1;
    logic [N-1:0]         ack;
    logic [TS_W-1:0]      fnd_ts_last_data, fnd_ts_last_data1;
    logic [LFSR_W-1:0]    fnd_decoded_data, fnd_decoded_data1;
    logic                 fnd_enable;
    logic                 fnd_ready;
    logic [LFSR_W-1:0]    fnd_polynomial, fnd_iteration;
    logic                 res_valid;
    logic [CW-1:0]        res_channel;
    logic [LFSR_W-1:0]    res_polynomial, res_iteration;
    logic                 res_timeout;

    logic [TS_W-1:0]   ch_ts0 [N];
    logic [TS_W-1:0]   ch_ts1 [N];
    logic [LFSR_W-1:0] ch_d0  [N];
    logic [LFSR_W-1:0] ch_d1  [N];

    for (genvar k = 0; k < N; k++) begin : g_pack
        assign ts0[k*TS_W +: TS_W]       = ch_ts0[k];
        assign ts1[k*TS_W +: TS_W]       = ch_ts1[k];
        assign data0[k*LFSR_W +: LFSR_W] = ch_d0[k];
        assign data1[k*LFSR_W +: LFSR_W] = ch_d1[k];
    end

    polynomial_finder_scheduler #(
        .N_CHANNELS     (N),
        .CH_W           (CW),
        .TIMEOUT_CYCLES (TMO),
        .RELEASE_CYCLES (REL)
    ) dut (
        .clk_72MHz         (clk_72MHz),
        .rst_n             (rst_n),
        .req               (req),
        .ts0               (ts0),
        .ts1               (ts1),
        .data0             (data0),
        .data1             (data1),
        .ack               (ack),
        .fnd_ts_last_data  (fnd_ts_last_data),
        .fnd_ts_last_data1 (fnd_ts_last_data1),
        .fnd_decoded_data  (fnd_decoded_data),
        .fnd_decoded_data1 (fnd_decoded_data1),
        .fnd_enable        (fnd_enable),
        .fnd_ready         (fnd_ready),
        .fnd_polynomial    (fnd_polynomial),
        .fnd_iteration     (fnd_iteration),
        .res_valid         (res_valid),
        .res_channel       (res_channel),
        .res_polynomial    (res_polynomial),
        .res_iteration     (res_iteration),
        .res_timeout       (res_timeout)
    );

    always #7 clk_72MHz = ~clk_72MHz;

    // Behavioural finder: ready high when idle, low while working, high with result after plan_lat cycles.
    bit               plan_hang;
    int               plan_lat;
    logic [LFSR_W-1:0] plan_poly, plan_iter;
    bit               f_active, f_hang;
    int               f_cnt;
    logic [LFSR_W-1:0] f_poly, f_iter;

    initial begin
        fnd_ready      = 1'b1;
        fnd_polynomial = '0;
        fnd_iteration  = '0;
        f_active       = 1'b0;
        f_hang         = 1'b0;
        f_cnt          = 0;
        f_poly         = '0;
        f_iter         = '0;
    end

    always @(posedge clk_72MHz) begin
        if (!f_active) begin
            if (fnd_enable) begin
                f_active  <= 1'b1;
                fnd_ready <= 1'b0;
                f_cnt     <= plan_lat;
                f_hang    <= plan_hang;
                f_poly    <= (fnd_decoded_data == fnd_decoded_data1) ? '0 : plan_poly;
                f_iter    <= (fnd_decoded_data == fnd_decoded_data1) ? '0 : plan_iter;
            end
        end else if (!fnd_enable) begin
            f_active  <= 1'b0;
            fnd_ready <= 1'b1;
        end else if (!fnd_ready && !f_hang) begin
            if (f_cnt <= 1) begin
                fnd_ready      <= 1'b1;
                fnd_polynomial <= f_poly;
                fnd_iteration  <= f_iter;
            end else begin
                f_cnt <= f_cnt - 1;
            end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;
    int exp_last;
    int low_run  = 0;
    int last_gap = 0;
    int res_seen = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_72MHz);
        #1;
        if (res_valid) res_seen++;
        if (!fnd_enable) low_run++;
        else if (low_run != 0) begin
            last_gap = low_run;
            low_run  = 0;
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] r, input int last);
        for (int off = 1; off <= int'(N); off++) begin
            int c;
            c = (last + off) % int'(N);
            if (r[c]) return c;
        end
        return -1;
    endfunction

    task automatic scramble(input bit equal_data);
        for (int k = 0; k < int'(N); k++) begin
            ch_ts0[k] = 24'($urandom);
            ch_ts1[k] = 24'($urandom);
            ch_d0[k]  = 17'($urandom);
            ch_d1[k]  = equal_data ? ch_d0[k] : 17'($urandom);
        end
    endtask

    // One full job: grant check, latched fields, result timing and contents.
    task automatic do_job(input logic [N-1:0] pat, input int exp_ch, input bit hang, input int lat,
                          input logic [LFSR_W-1:0] poly, input logic [LFSR_W-1:0] iter);
        int n;
        int exp_n;
        bit exp_tmo;
        logic [LFSR_W-1:0] ep, ei;
        logic [81:0] latched;
        plan_hang = hang;
        plan_lat  = lat;
        plan_poly = poly;
        plan_iter = iter;
        req = pat;
        n = 0;
        do begin
            tick();
            n++;
        end while (ack == '0 && n < 200);
        chk("ack_seen", 128'(ack != '0), 128'(1));
        if (ack == '0) return;
        chk("ack_onehot", 128'(ack), 128'(1 << exp_ch));
        chk("enable_on", 128'(fnd_enable), 128'(1));
        chk("release_gap_ge2", 128'(last_gap >= int'(REL)), 128'(1));
        latched = {ch_ts0[exp_ch], ch_ts1[exp_ch], ch_d0[exp_ch], ch_d1[exp_ch]};
        chk("fnd_fields", 128'({fnd_ts_last_data, fnd_ts_last_data1, fnd_decoded_data, fnd_decoded_data1}),
            128'(latched));
        exp_last = exp_ch;
        if (hang || lat + 2 > int'(TMO)) begin
            exp_tmo = 1'b1; ep = '0; ei = '0; exp_n = int'(TMO);
        end else begin
            exp_tmo = 1'b0; exp_n = lat + 2;
            if (ch_d0[exp_ch] == ch_d1[exp_ch]) begin ep = '0; ei = '0; end
            else begin ep = poly; ei = iter; end
        end
        scramble($urandom_range(0, 1) == 1);
        tick();
        chk("ack_pulse", 128'(ack), 128'(0));
        n = 1;
        while (!res_valid && n < 300) begin
            tick();
            n++;
        end
        chk("res_latency", 128'(n), 128'(exp_n));
        chk("res_channel", 128'(res_channel), 128'(exp_ch));
        chk("res_poly", 128'(res_polynomial), 128'(ep));
        chk("res_iter", 128'(res_iteration), 128'(ei));
        chk("res_timeout", 128'(res_timeout), 128'(exp_tmo));
        chk("enable_off", 128'(fnd_enable), 128'(0));
        chk("fnd_hold", 128'({fnd_ts_last_data, fnd_ts_last_data1, fnd_decoded_data, fnd_decoded_data1}),
            128'(latched));
        tick();
        chk("res_pulse", 128'(res_valid), 128'(0));
    endtask

    typedef struct {
        logic [N-1:0]      req;
        int                exp_ch;
        bit                hang;
        int                lat;
        logic [LFSR_W-1:0] poly;
        logic [LFSR_W-1:0] iter;
        bit                set_f;
        logic [TS_W-1:0]   t0, t1;
        logic [LFSR_W-1:0] d0, d1;
    } vec_t;

    vec_t vecs [11];

    initial begin
        int n;
        vecs[0]  = '{4'b1111, 0, 1'b0, 10, 17'h00001, 17'd5,   1'b0, 24'h0, 24'h0, 17'h0, 17'h0};
        vecs[1]  = '{4'b1111, 1, 1'b0, 12, POLY_17E04, 17'd100, 1'b0, 24'h0, 24'h0, 17'h0, 17'h0};
        vecs[2]  = '{4'b1111, 2, 1'b0, 8,  17'h00003, 17'd7,   1'b0, 24'h0, 24'h0, 17'h0, 17'h0};
        vecs[3]  = '{4'b1111, 3, 1'b0, 15, 17'h00004, 17'd9,   1'b0, 24'h0, 24'h0, 17'h0, 17'h0};
        vecs[4]  = '{4'b1111, 0, 1'b0, 5,  17'h00005, 17'd11,  1'b0, 24'h0, 24'h0, 17'h0, 17'h0};
        vecs[5]  = '{4'b0100, 2, 1'b0, 20, POLY_1D258, 17'd16, 1'b1, 24'h000100, 24'h000200, 17'h00A5A, 17'h0F0F0};
        vecs[6]  = '{4'b0010, 1, 1'b1, 10, 17'h1FFFF, 17'd1,   1'b1, 24'h1, 24'h2, 17'h00011, 17'h00022};
        vecs[7]  = '{4'b1000, 3, 1'b0, 9,  POLY_1D258, 17'd3,  1'b1, 24'h10, 24'h20, 17'h12345, 17'h12345};
        vecs[8]  = '{4'b0001, 0, 1'b0, 62, POLY_17E04, 17'd77, 1'b1, 24'h5, 24'h6, 17'h00001, 17'h00002};
        vecs[9]  = '{4'b0001, 0, 1'b0, 61, POLY_1D258, 17'd1,  1'b1, 24'h7, 24'h8, 17'h00003, 17'h00004};
        vecs[10] = '{4'b0011, 1, 1'b0, 63, POLY_1D258, 17'd2,  1'b1, 24'h9, 24'hA, 17'h00005, 17'h00006};

        rst_n = 1'b0;
        req   = '0;
        plan_hang = 1'b0; plan_lat = 4; plan_poly = '0; plan_iter = '0;
        scramble(1'b0);
        repeat (3) tick();
        chk("rst_ack", 128'(ack), 128'(0));
        chk("rst_enable", 128'(fnd_enable), 128'(0));
        chk("rst_res_valid", 128'(res_valid), 128'(0));
        chk("rst_res_fields", 128'({res_channel, res_polynomial, res_iteration, res_timeout}), 128'(0));
        chk("rst_fnd_fields", 128'({fnd_ts_last_data, fnd_ts_last_data1, fnd_decoded_data, fnd_decoded_data1}),
            128'(0));
        rst_n = 1'b1;
        exp_last = int'(N) - 1;
        tick();
        chk("flush_en_c1", 128'(fnd_enable), 128'(0));
        tick();
        chk("flush_en_c2", 128'(fnd_enable), 128'(0));

        foreach (vecs[i]) begin
            if (vecs[i].set_f) begin
                ch_ts0[vecs[i].exp_ch] = vecs[i].t0;
                ch_ts1[vecs[i].exp_ch] = vecs[i].t1;
                ch_d0[vecs[i].exp_ch]  = vecs[i].d0;
                ch_d1[vecs[i].exp_ch]  = vecs[i].d1;
            end
            do_job(vecs[i].req, vecs[i].exp_ch, vecs[i].hang, vecs[i].lat, vecs[i].poly, vecs[i].iter);
        end

        for (int j = 0; j < 30; j++) begin
            logic [N-1:0] pat;
            pat = N'($urandom_range(1, 15));
            scramble($urandom_range(0, 3) == 0);
            do_job(pat, rr_pick(pat, exp_last), $urandom_range(0, 9) == 0, int'($urandom_range(1, 70)),
                   17'($urandom), 17'($urandom));
        end

        // Reset in the middle of a hung job: no result, flush, then the pending channel 1.
        plan_hang = 1'b1;
        req = 4'b0001;
        n = 0;
        do begin
            tick();
            n++;
        end while (ack == '0 && n < 200);
        chk("mid_ack_seen", 128'(ack), 128'(1 << rr_pick(4'b0001, exp_last)));
        repeat (10) tick();
        res_seen = 0;
        rst_n = 1'b0;
        req = 4'b0010;
        ch_ts0[1] = 24'hABCDEF; ch_ts1[1] = 24'h123456; ch_d0[1] = 17'h0AAAA; ch_d1[1] = 17'h15555;
        plan_hang = 1'b0; plan_lat = 5; plan_poly = POLY_17E04; plan_iter = 17'd42;
        tick();
        chk("midrst_ack", 128'(ack), 128'(0));
        chk("midrst_enable", 128'(fnd_enable), 128'(0));
        chk("midrst_res", 128'({res_valid, res_channel, res_polynomial, res_iteration, res_timeout}), 128'(0));
        tick();
        rst_n = 1'b1;
        exp_last = int'(N) - 1;
        tick();
        chk("midrst_flush_c1", 128'({fnd_enable, ack}), 128'(0));
        tick();
        chk("midrst_flush_c2", 128'({fnd_enable, ack}), 128'(0));
        tick();
        chk("midrst_grant_ch1", 128'(ack), 128'(4'b0010));
        chk("midrst_enable_on", 128'(fnd_enable), 128'(1));
        chk("midrst_no_res", 128'(res_seen), 128'(0));
        req = '0;
        n = 0;
        while (!res_valid && n < 300) begin
            tick();
            n++;
        end
        chk("midrst_res_latency", 128'(n), 128'(5 + 2));
        chk("midrst_res", 128'({res_channel, res_polynomial, res_iteration, res_timeout}),
            128'({2'd1, POLY_17E04, 17'd42, 1'b0}));
        repeat (5) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/polynomial_finder_scheduler.md
# polynomial_finder_scheduler

Shares one `polynomial_finder` between `N_CHANNELS` photodiode decode channels. Each channel presents a pair of consecutive decoded samples (timestamp plus 17-bit LFSR word). The scheduler grants channels round-robin, drives the finder's enable handshake, and enforces a timeout. It returns the polynomial and iteration result tagged with the channel index. It sits between the per-sensor decoders and the single finder instance in the tracker top level.

## Interface
Parameters:
- `N_CHANNELS`, 4: number of requesting channels (2..16)
- `CH_W`, 2: channel index width, `$clog2(N_CHANNELS)`
- `TIMEOUT_CYCLES`, 2097152: maximum cycles a job may hold the finder
- `RELEASE_CYCLES`, 2: cycles `fnd_enable` is held low between jobs (minimum 2)

Ports:
- `clk_72MHz  in  1`: single clock
- `rst_n  in  1`: asynchronous, active-low reset
- `req  in  N_CHANNELS`: level, channel has a sample pair pending
- `ts0, ts1  in  24*N_CHANNELS`: first and second timestamps, channel k at `[24k+:24]`
- `data0, data1  in  17*N_CHANNELS`: first and second decoded words, channel k at `[17k+:17]`
- `ack  out  N_CHANNELS`: one-cycle pulse, channel's pair latched
- `fnd_ts_last_data, fnd_ts_last_data1  out  24`: to finder
- `fnd_decoded_data, fnd_decoded_data1  out  17`: to finder
- `fnd_enable  out  1`: to finder
- `fnd_ready  in  1`, `fnd_polynomial  in  17`, `fnd_iteration  in  17`: from finder
- `res_valid  out  1`: one-cycle pulse
- `res_channel  out  CH_W`: channel the result belongs to
- `res_polynomial, res_iteration  out  17`: finder result; 0 means no match
- `res_timeout  out  1`: result was produced by the timeout

## Operation
- States: FLUSH, IDLE, START, BUSY, RELEASE.
- **Reset:** entering reset forces all outputs to 0 and `ack` to 0; state becomes FLUSH. The finder has no reset, so FLUSH holds `fnd_enable` low for `RELEASE_CYCLES` before moving to IDLE.
- **IDLE:** if any `req` bit is high, select the lowest-index requester at or after `last_grant+1`, with wrap-around. `last_grant` resets to `N_CHANNELS-1`, so channel 0 wins first.
  - Latch that channel's four fields into the `fnd_*` registers.
  - Pulse `ack[k]`, set `fnd_enable` to 1, store the grant, clear the timeout counter, and go to START.
  - `req` is sampled only in IDLE.
- **Requester rule:** after `ack` the requester may update fields or drop `req`. If `req` is still high, it is served again in round-robin order.
- **START:** wait for `fnd_ready == 0`, which proves the finder left IDLE, then go to BUSY.
- **BUSY:** on `fnd_ready == 1`:
  - capture `fnd_polynomial` and `fnd_iteration`;
  - pulse `res_valid` with `res_timeout = 0`;
  - drop `fnd_enable`;
  - go to RELEASE.
- **Timeout:** the counter increments in START and BUSY. When it reaches `TIMEOUT_CYCLES-1`, abort:
  - drop `fnd_enable`;
  - pulse `res_valid` with polynomial 0, iteration 0, `res_timeout = 1`;
  - go to RELEASE.
  - If ready-high and timeout occur in the same cycle, the ready capture wins.
- **RELEASE:** hold `fnd_enable` low for `RELEASE_CYCLES`, then return to IDLE.
- **Output hold:** `fnd_*` data holds its last value outside jobs. `res_*` fields hold until the next `res_valid`.

## Timing
- `req` high in IDLE at edge t: `ack` and `fnd_enable` are high after edge t; `ack` is low after t+1.
- Finder drops `fnd_ready` after t+1, so START lasts 1–2 cycles.
- `fnd_ready` high observed at edge r: `res_valid` is high and `fnd_enable` low after edge r, for one cycle.
- Next earliest `ack` arrives `RELEASE_CYCLES+1` edges after r.
- Under continuous requests, no channel waits longer than `N_CHANNELS-1` other jobs.
- Timeout counter is 22 bits wide, saturating.
- `rst_n` asserted mid-job aborts the job with no `res_valid`.

## Structure
- Shared package `vive_pkg` holds:
  - `TS_W = 24`, `LFSR_W = 17`;
  - `POLY_1D258 = 17'h1d258` and `POLY_17E04 = 17'h17e04`;
  - the state enum.
- Sub-module `rr_arbiter` (parameter N): inputs `req`, `last_grant`, `advance`; outputs one-hot `grant` and its index.
- The finder instance lives outside this block, so the bench can substitute a behavioural model.

## Test plan
- **Reset and flush:** reset release → `fnd_enable` stays low for 2 cycles; all outputs are 0.
- **Single job:** `req[2]=1` with `ts0=0x000100`, `ts1=0x000200`, `data0=0x00A5A`, `data1=0x0F0F0`; model answers poly `0x1D258`, iteration 16 after 20 cycles → `ack[2]` pulse, `res_valid` with channel 2, `0x1D258`, 16, `res_timeout=0`.
- **Round robin:** `req=4'b1111` held → grants in order 0,1,2,3,0; each `ack` is one cycle; `fnd_enable` is low for at least 2 cycles between jobs.
- **Timeout:** `TIMEOUT_CYCLES=64`, model never raises ready → `res_valid` at cycle 64 with `res_timeout=1`, poly 0, iteration 0; the next job starts normally.
- **No match:** model returns ready with poly 0 (equal data words) → `res_valid` with poly 0, `res_timeout=0`.
- **Reset mid-BUSY:** `rst_n` low during a job → no `res_valid`; FLUSH occurs after release, and a pending `req[1]` is then served first.
